// File: rtl/led_pattern_pkg.sv
// ============================================================================
// Module   : led_pattern_pkg
// Purpose  : Shared widths, pattern encoding and initial LED values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pattern_pkg;

  localparam int LED_W = 8;
  localparam int SW_W  = 3;

  typedef enum logic [SW_W-1:0] {
    OFF    = 3'd0,
    ON     = 3'd1,
    BIN    = 3'd2,
    ROTL   = 3'd3,
    ROTR   = 3'd4,
    BOUNCE = 3'd5,
    ALT    = 3'd6,
    GRAY   = 3'd7
  } pat_e;

  function automatic logic [LED_W-1:0] init_val(input pat_e pat);
    logic [LED_W-1:0] val;
    case (pat)
      ON:      val = 8'hFF;
      ROTL:    val = 8'h01;
      ROTR:    val = 8'h80;
      BOUNCE:  val = 8'h01;
      ALT:     val = 8'hAA;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_prescaler.sv
// ============================================================================
// Module   : led_prescaler
// Purpose  : Emits one tick every PRESCALE enabled cycles; clr restarts count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] c_last = 16'(PRESCALE - 1);

  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 16'd0;
    end else if (clr) begin
      r_count <= 16'd0;
    end else if (enable) begin
      r_count <= (r_count == c_last) ? 16'd0 : r_count + 16'd1;
    end
  end

  assign tick = enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Switch-selected 8-bit LED pattern generator with registered output.
//            Define LED_PRESCALE_EN to step only every PRESCALE enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led
);

  localparam logic [0:0] DIR_LEFT  = 1'b0;
  localparam logic [0:0] DIR_RIGHT = 1'b1;

  logic [SW_W-1:0]  r_sw_q;
  logic [7:0]       r_cnt;
  logic [0:0]       r_dir;
  logic [LED_W-1:0] r_led;

  logic [7:0]       w_cnt_inc;
  logic [7:0]       w_cnt_nxt;
  logic [0:0]       w_dir_nxt;
  logic [LED_W-1:0] w_led_nxt;
  logic             w_sw_change;
  logic             w_tick;
  logic             w_step;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_prescale_range_err
    $error("led_pattern_gen: PRESCALE out of range 1..65535");
  end

  assign w_sw_change = (switch != r_sw_q);

`ifdef LED_PRESCALE_EN
  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clr    (w_sw_change),
    .tick   (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_step    = enable && w_tick;
  assign w_cnt_inc = r_cnt + 8'd1;

  // A switch change reloads the new pattern regardless of enable/tick.
  always_comb begin
    w_led_nxt = r_led;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (w_sw_change) begin
      w_led_nxt = init_val(pat_e'(switch));
      w_cnt_nxt = 8'd0;
      w_dir_nxt = DIR_LEFT;
    end else if (w_step) begin
      case (pat_e'(r_sw_q))
        OFF:  w_led_nxt = 8'h00;
        ON:   w_led_nxt = 8'hFF;
        BIN: begin
          w_cnt_nxt = w_cnt_inc;
          w_led_nxt = w_cnt_inc;
        end
        ROTL: w_led_nxt = {r_led[6:0], r_led[7]};
        ROTR: w_led_nxt = {r_led[0], r_led[7:1]};
        BOUNCE: begin
          // Turn around at the ends so neither end LED is shown twice.
          if (r_dir == DIR_LEFT) begin
            if (r_led == 8'h80) begin
              w_dir_nxt = DIR_RIGHT;
              w_led_nxt = 8'h40;
            end else begin
              w_led_nxt = r_led << 1;
            end
          end else begin
            if (r_led == 8'h01) begin
              w_dir_nxt = DIR_LEFT;
              w_led_nxt = 8'h02;
            end else begin
              w_led_nxt = r_led >> 1;
            end
          end
        end
        ALT:  w_led_nxt = ~r_led;
        GRAY: begin
          w_cnt_nxt = w_cnt_inc;
          w_led_nxt = w_cnt_inc ^ (w_cnt_inc >> 1);
        end
        default: w_led_nxt = r_led;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_q <= '0;
      r_cnt  <= 8'h00;
      r_dir  <= DIR_LEFT;
      r_led  <= 8'h00;
    end else begin
      r_sw_q <= switch;
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_led  <= w_led_nxt;
    end
  end

  assign led = r_led;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// ============================================================================
// Module   : tb_led_pattern_gen
// Purpose  : Self-checking bench; reference model computes LED value from
//            (pattern, step count) arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] switch;
  logic [7:0] led;

  int n_checks;
  int n_errors;

  // Reference model state: last sampled switch, active pattern, steps since load.
  int m_sw_q;
  int m_pat;
  int m_k;

  logic [7:0] c_init [8];

  led_pattern_gen #(
    .PRESCALE (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: led=%02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_led(input int pat, input int k);
    int m;
    int pos;
    int g;
    logic [7:0] v;
    case (pat)
      0: v = 8'h00;
      1: v = 8'hFF;
      2: v = 8'(k % 256);
      3: v = 8'(1 << (k % 8));
      4: v = 8'(128 >> (k % 8));
      5: begin
        m   = k % 14;
        pos = (m <= 7) ? m : 14 - m;
        v   = 8'(1 << pos);
      end
      6: v = (k % 2 == 0) ? 8'hAA : 8'h55;
      default: begin
        g = k % 256;
        v = 8'(g ^ (g >> 1));
      end
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_sw_q = 0;
    m_pat  = 0;
    m_k    = 0;
  endtask

  // Drive inputs, take one edge, update the model, compare 1 time unit later.
  task automatic step(input string tag, input int sw, input logic en);
    switch = 3'(sw);
    enable = en;
    @(posedge clk);
    if (sw != m_sw_q) begin
      m_pat = sw;
      m_k   = 0;
    end else if (en) begin
      m_k++;
    end
    m_sw_q = sw;
    #1;
    check_value(tag, led, model_led(m_pat, m_k));
  endtask

  initial begin
    int sw;
    int prev;
    n_checks = 0;
    n_errors = 0;
    c_init = '{8'h00, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h01, 8'hAA, 8'h00};

    // Reset held with switch=5
    rst    = 1'b1;
    enable = 1'b1;
    switch = 3'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_led", led, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step("post_reset_load", 5, 1'b1);
    check_value("post_reset_init", led, 8'h01);

    // ROTL full cycle, then hold with enable low, then resume
    step("rotl_load", 3, 1'b1);
    for (int i = 0; i < 8; i++) step("rotl", 3, 1'b1);
    check_value("rotl_wrap", led, 8'h01);
    for (int i = 0; i < 3; i++) step("rotl", 3, 1'b1);
    for (int i = 0; i < 3; i++) step("rotl_hold", 3, 1'b0);
    check_value("rotl_hold_val", led, 8'h08);
    for (int i = 0; i < 2; i++) step("rotl_resume", 3, 1'b1);

    // BOUNCE 16 steps
    step("bounce_load", 5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step("bounce", 5, 1'b1);
      if (i == 6)  check_value("bounce_top", led, 8'h80);
      if (i == 7)  check_value("bounce_turn_r", led, 8'h40);
      if (i == 14) check_value("bounce_turn_l", led, 8'h02);
    end
    check_value("bounce_end", led, 8'h04);

    // BIN wrap
    step("bin_load", 2, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step("bin", 2, 1'b1);
      if (i == 254) check_value("bin_ff", led, 8'hFF);
    end
    check_value("bin_wrap", led, 8'h00);

    // GRAY first steps
    step("gray_load", 7, 1'b1);
    step("gray", 7, 1'b1);
    check_value("gray_1", led, 8'h01);
    step("gray", 7, 1'b1);
    check_value("gray_2", led, 8'h03);
    step("gray", 7, 1'b1);
    check_value("gray_3", led, 8'h02);
    for (int i = 0; i < 300; i++) step("gray_run", 7, 1'b1);

    // ALT and ROTR
    step("alt_load", 6, 1'b1);
    for (int i = 0; i < 5; i++) step("alt", 6, 1'b1);
    step("rotr_load", 4, 1'b1);
    for (int i = 0; i < 10; i++) step("rotr", 4, 1'b1);

    // Random switch every cycle, enable high
    prev = m_sw_q;
    for (int i = 0; i < 40; i++) begin
      sw = int'($urandom_range(0, 7));
      step("rand_sw", sw, 1'b1);
      if (sw != prev) check_value("rand_init", led, c_init[sw]);
      prev = sw;
    end

    // Random enable with occasional switch changes
    sw = int'($urandom_range(0, 7));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw = int'($urandom_range(0, 7));
      step("rand_mix", sw, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-pattern, then reload on same nonzero switch
    step("pre_rst_load", 1, 1'b1);
    step("pre_rst", 6, 1'b1);
    step("pre_rst", 6, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_value("async_reset", led, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_reload", 6, 1'b1);
    check_value("post_rst_alt", led, 8'hAA);
    step("post_rst_alt_step", 6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
